// File: rtl/layer_ctl.sv
// layer_ctl
// Decodes SPI command frames into per-layer pixel RAM writes and a broadcast
// refresh pulse.
//
// A pixel-write frame is: CMD_WR, layer number, then three bytes per pixel in
// G, R, B order. Pixels are numbered from 0 and each frame covers at most
// PIXELS pixels. A refresh frame is the single byte CMD_RF.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous reset, active low
//   spi_cs_n_in      chip select (already synchronised); high ends the frame
//   spi_byte_rdy_in  one-cycle strobe, spi_byte_data_in valid
//   spi_byte_data_in received byte
//   layer_en_out     one-hot write strobe, one cycle per accepted pixel byte
//   data_idx_out     pixel index of the current write (held)
//   byte_sel_out     byte-lane enable of the current write (held)
//   spi_data_out     byte being written (held)
//   data_rdy_out     one-cycle refresh pulse to all layers
module layer_ctl #(
    parameter int         LAYERS = 8,
    parameter int         PIXELS = 64,
    parameter logic [7:0] CMD_WR = 8'h2A,
    parameter logic [7:0] CMD_RF = 8'h2B
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              spi_cs_n_in,
    input  logic              spi_byte_rdy_in,
    input  logic [7:0]        spi_byte_data_in,
    output logic [LAYERS-1:0] layer_en_out,
    output logic [5:0]        data_idx_out,
    output logic [3:0]        byte_sel_out,
    output logic [7:0]        spi_data_out,
    output logic              data_rdy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LAYER,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]        r_layer;
    logic [5:0]        r_pixel;
    logic [1:0]        r_lane;

    logic [LAYERS-1:0] r_layer_en;
    logic [5:0]        r_idx;
    logic [3:0]        r_sel;
    logic [7:0]        r_data;
    logic              r_data_rdy;

    logic              w_wr;         // accept a pixel byte this cycle
    logic              w_rf;         // refresh command accepted this cycle
    logic              w_layer_ok;   // valid layer number accepted this cycle
    logic              w_last;       // current byte is lane 2 of the final pixel
    logic [3:0]        w_sel;
    logic [LAYERS-1:0] w_layer_onehot;

    // Next-state and per-cycle decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rf        = 1'b0;
        w_layer_ok  = 1'b0;
        w_last      = (r_lane == 2'd2) && (r_pixel == 6'(PIXELS - 1));

        // Deasserted chip select wins over any byte arriving in the same cycle.
        if (spi_cs_n_in) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_CMD;
                S_CMD: begin
                    if (spi_byte_rdy_in) begin
                        if (spi_byte_data_in == CMD_WR) begin
                            w_state_nxt = S_LAYER;
                        end else begin
                            w_state_nxt = S_IGNORE;
                            w_rf        = (spi_byte_data_in == CMD_RF);
                        end
                    end
                end
                S_LAYER: begin
                    if (spi_byte_rdy_in) begin
                        if (spi_byte_data_in < 8'(LAYERS)) begin
                            w_state_nxt = S_DATA;
                            w_layer_ok  = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_DATA: begin
                    if (spi_byte_rdy_in) begin
                        w_wr = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: w_state_nxt = S_IGNORE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Lane order on the wire is G, R, B; lane 3 is never produced.
    always_comb begin
        case (r_lane)
            2'd0:    w_sel = 4'b0100;
            2'd1:    w_sel = 4'b0010;
            default: w_sel = 4'b0001;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LAYERS; i++) begin
            w_layer_onehot[i] = (r_layer == 4'(i));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: registers update with non-blocking assignments so every always_ff sees pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Frame position counters; cleared whenever the frame ends.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_layer <= '0;
            r_pixel <= '0;
            r_lane  <= '0;
        end else if (spi_cs_n_in) begin
            r_pixel <= '0;
            r_lane  <= '0;
        end else if (w_layer_ok) begin
            r_layer <= spi_byte_data_in[3:0];
            r_pixel <= '0;
            r_lane  <= '0;
        end else if (w_wr) begin
            if (r_lane == 2'd2) begin
                r_lane  <= '0;
                r_pixel <= r_pixel + 6'd1;
            end else begin
                r_lane  <= r_lane + 2'd1;
            end
        end
    end

    // Registered outputs: strobes pulse for one cycle, write fields hold.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_layer_en <= '0;
            r_idx      <= '0;
            r_sel      <= '0;
            r_data     <= '0;
            r_data_rdy <= 1'b0;
        end else begin
            r_layer_en <= '0;
            r_data_rdy <= w_rf;
            if (w_wr) begin
                r_layer_en <= w_layer_onehot;
                r_idx      <= r_pixel;
                r_sel      <= w_sel;
                r_data     <= spi_byte_data_in;
            end
        end
    end

    assign layer_en_out = r_layer_en;
    assign data_idx_out = r_idx;
    assign byte_sel_out = r_sel;
    assign spi_data_out = r_data;
    assign data_rdy_out = r_data_rdy;

endmodule

// File: tb/tb_layer_ctl.sv
// tb_layer_ctl
// Self-checking bench for layer_ctl. Frames are built as byte lists; the
// expected write/refresh events of each frame are derived from the frame
// contents by position (byte i>=2 of a valid write frame is pixel (i-2)/3,
// lane (i-2)%3) and queued with the cycle they must appear in. A monitor
// compares every observed strobe against that queue.
module tb_layer_ctl;

    localparam int LAYERS = 8;
    localparam int PIXELS = 64;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs_n  = 1'b1;
    logic              rdy   = 1'b0;
    logic [7:0]        din   = 8'h00;
    logic [LAYERS-1:0] layer_en;
    logic [5:0]        idx;
    logic [3:0]        sel;
    logic [7:0]        dout;
    logic              data_rdy;

    layer_ctl #(
        .LAYERS(LAYERS),
        .PIXELS(PIXELS),
        .CMD_WR(8'h2A),
        .CMD_RF(8'h2B)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .spi_cs_n_in     (cs_n),
        .spi_byte_rdy_in (rdy),
        .spi_byte_data_in(din),
        .layer_en_out    (layer_en),
        .data_idx_out    (idx),
        .byte_sel_out    (sel),
        .spi_data_out    (dout),
        .data_rdy_out    (data_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       cyc;
        logic              is_rdy;
        logic [LAYERS-1:0] en;
        logic [5:0]        idx;
        logic [3:0]        sel;
        logic [7:0]        data;
    } evt_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    evt_t        exp_q[$];
    logic [7:0]  frame_q[$];
    logic [5:0]  last_idx  = '0;
    logic [3:0]  last_sel  = '0;
    logic [7:0]  last_data = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] sel_of(input int lane);
        case (lane)
            0:       return 4'b0100;
            1:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (rst_n) begin
            if (layer_en != '0 || data_rdy) begin
                check("en_onehot", 32'($countones(layer_en) <= 1), 32'd1);
                check("rdy_with_en", 32'(data_rdy && (layer_en != '0)), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", {23'd0, data_rdy, layer_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_cycle", cycle, e.cyc);
                    check("evt_rdy", 32'(data_rdy), 32'(e.is_rdy));
                    check("evt_en", 32'(layer_en), 32'(e.en));
                    if (!e.is_rdy) begin
                        check("evt_idx", 32'(idx), 32'(e.idx));
                        check("evt_sel", 32'(sel), 32'(e.sel));
                        check("evt_data", 32'(dout), 32'(e.data));
                    end
                end
            end else if (exp_q.size() > 0 && cycle >= exp_q[0].cyc) begin
                e = exp_q.pop_front();
                check("missing_evt", {23'd0, data_rdy, layer_en},
                      e.is_rdy ? 32'h100 : 32'(e.en));
            end
        end
    end

    task automatic check_hold(input string tag);
        check({tag, "_idx"}, 32'(idx), 32'(last_idx));
        check({tag, "_sel"}, 32'(sel), 32'(last_sel));
        check({tag, "_data"}, 32'(dout), 32'(last_data));
    endtask

    // Sends frame_q as one frame with random inter-byte gaps (0 = back-to-back).
    task automatic send_frame(input int gap_max, input bit keep_open);
        logic              valid_wr;
        logic [LAYERS-1:0] one;
        int                k;
        evt_t              e;
        one = 1;
        @(negedge clk) cs_n = 1'b0;
        @(negedge clk);
        valid_wr = (frame_q.size() >= 2) && (frame_q[0] == 8'h2A) && (frame_q[1] < LAYERS);
        for (int i = 0; i < frame_q.size(); i++) begin
            rdy = 1'b1;
            din = frame_q[i];
            if (i == 0 && frame_q[0] == 8'h2B) begin
                e = '{cyc: cycle + 1, is_rdy: 1'b1, en: '0, idx: '0, sel: '0, data: '0};
                exp_q.push_back(e);
            end
            if (valid_wr && i >= 2 && (i - 2) < PIXELS * 3) begin
                k = i - 2;
                e = '{cyc: cycle + 1, is_rdy: 1'b0, en: one << frame_q[1],
                      idx: 6'(k / 3), sel: sel_of(k % 3), data: frame_q[i]};
                exp_q.push_back(e);
                last_idx  = e.idx;
                last_sel  = e.sel;
                last_data = e.data;
            end
            @(negedge clk);
            rdy = 1'b0;
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        if (!keep_open) begin
            cs_n = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en"}, 32'(layer_en), 32'd0);
        check({tag, "_idx"}, 32'(idx), 32'd0);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_data"}, 32'(dout), 32'd0);
        check({tag, "_rdy"}, 32'(data_rdy), 32'd0);
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int len;
        int sel_r;

        // Reset state.
        #12;
        check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Byte strobe while chip select is high is ignored.
        rdy = 1'b1; din = 8'h2B;
        @(negedge clk) rdy = 1'b0;
        repeat (2) @(negedge clk);

        // 1: three lanes of pixel 0 on layer 3.
        frame_q = '{8'h2A, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(0, 1'b0);
        check("t1_idx", 32'(idx), 32'd0);
        check("t1_sel", 32'(sel), 32'b0001);
        check("t1_data", 32'(dout), 32'h33);

        // 2: full layer plus extra bytes.
        frame_q = '{8'h2A, 8'h00};
        for (int i = 0; i < PIXELS * 3 + 5; i++) frame_q.push_back(8'($urandom));
        send_frame(1, 1'b0);
        check("t2_last_idx", 32'(idx), 32'd63);
        check("t2_last_sel", 32'(sel), 32'b0001);
        check_hold("t2_hold");

        // 3: refresh.
        frame_q = '{8'h2B};
        send_frame(0, 1'b0);

        // 4: invalid layer, unknown command.
        frame_q = '{8'h2A, 8'h08, 8'h01, 8'h02, 8'h03};
        send_frame(1, 1'b0);
        frame_q = '{8'h55, 8'h2B, 8'h2A, 8'h01, 8'h02};
        send_frame(1, 1'b0);
        check_hold("t4_hold");

        // 5: restart after chip select, then cs rising together with a byte.
        frame_q = '{8'h2A, 8'h01, 8'hAA, 8'hBB};
        send_frame(0, 1'b0);
        frame_q = '{8'h2A, 8'h01, 8'hCC};
        send_frame(0, 1'b0);
        check("t5_idx", 32'(idx), 32'd0);
        check("t5_sel", 32'(sel), 32'b0100);
        check("t5_data", 32'(dout), 32'hCC);
        frame_q = '{8'h2A, 8'h05, 8'h12};
        send_frame(0, 1'b1);
        cs_n = 1'b1; rdy = 1'b1; din = 8'h34;
        @(negedge clk) rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_hold("t5_drop");

        // 6: asynchronous reset in the middle of DATA.
        frame_q = '{8'h2A, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6_async");
        last_idx = '0; last_sel = '0; last_data = '0;
        @(negedge clk);
        cs_n  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check_hold("t6_after");
        frame_q = '{8'h2A, 8'h07, 8'h9A, 8'hBC};
        send_frame(0, 1'b0);
        check_hold("t6_new");

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            len   = (f % 10 == 7) ? 200 : $urandom_range(12, 0);
            sel_r = $urandom_range(3, 0);
            frame_q = {};
            frame_q.push_back(sel_r < 2 ? 8'h2A : (sel_r == 2 ? 8'h2B : 8'($urandom)));
            frame_q.push_back(8'($urandom_range(11, 0)));
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            send_frame(2, 1'b0);
            check_hold("rnd_hold");
        end

        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
